ps2_key_decoder: RTL and testbench



---
 rtl/ps2_key_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Receives PS/2 keyboard frames, decodes set-2 scancodes and drives
// active-low paddle key states that stand in for the push-button pairs.
//
// Ports:
//   clk        in   system clock (50 MHz)
//   rst        in   synchronous active-high reset
//   ps2_clk    in   raw PS/2 clock from pad (asynchronous)
//   ps2_dat    in   raw PS/2 data from pad (asynchronous)
//   keys_left  out  [1]=W, [0]=S, active-low
//   keys_right out  [1]=Up arrow, [0]=Down arrow, active-low
//   scancode   out  last correctly received byte
//   code_valid out  one-cycle pulse when scancode is updated
//   frame_err  out  one-cycle pulse when a frame is discarded
//
// Optional build macro PS2_ERR_RELEASE_EN: every frame_err also releases
// all keys and clears the break/extended prefixes in the same cycle.
module ps2_key_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [1:0] keys_left,
   output logic [1:0] keys_right,
   output logic [7:0] scancode,
   output logic       code_valid,
   output logic       frame_err
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   // Two-FF synchronizers, bit 0 = ps2_clk, bit 1 = ps2_dat.
   logic [1:0] raw_bits;
   logic [1:0] sync_bits;
   assign raw_bits = {ps2_dat, ps2_clk};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         logic meta_q;
         logic sync_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               meta_q <= 1'b1;
               sync_q <= 1'b1;
            end else begin
               meta_q <= raw_bits[gi];
               sync_q <= meta_q;
            end
         end
         assign sync_bits[gi] = sync_q;
      end
   endgenerate

   logic clk_s;
   logic dat_s;
   assign clk_s = sync_bits[0];
   assign dat_s = sync_bits[1];

   // Glitch filter: the filtered level follows the synchronized clock only
   // after FILTER_LEN consecutive samples that disagree with it.
   logic          filt_q;
   logic [FW-1:0] fcnt_q;
   logic          fcnt_full;
   logic          fall;

   assign fcnt_full = (fcnt_q == FW'(FILTER_LEN - 1));
   // The falling edge is the cycle the filter flips 1->0.
   assign fall      = filt_q & ~clk_s & fcnt_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= 1'b1;
         fcnt_q <= '0;
      end else if (clk_s == filt_q) begin
         fcnt_q <= '0;
      end else if (fcnt_full) begin
         filt_q <= clk_s;
         fcnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_q + 1'b1;
      end
   end

   // Receiver and decoder state
   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [7:0]    scancode_q, scancode_d;
   logic [1:0]    keys_left_q, keys_left_d;
   logic [1:0]    keys_right_q, keys_right_d;
   logic          brk_q, brk_d;
   logic          ext_q, ext_d;
   logic          code_valid_q, code_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          accept;
   logic          err;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      to_cnt_d     = to_cnt_q;
      scancode_d   = scancode_q;
      keys_left_d  = keys_left_q;
      keys_right_d = keys_right_q;
      brk_d        = brk_q;
      ext_d        = ext_q;
      accept       = 1'b0;
      err          = 1'b0;

      if (fall) begin
         to_cnt_d = '0;
         case (state_q)
            S_IDLE: begin
               if (!dat_s) begin
                  state_d   = S_DATA;
                  bit_cnt_d = '0;
               end else begin
                  err = 1'b1;
               end
            end
            S_DATA: begin
               shift_d   = {dat_s, shift_q[7:1]};   // LSB arrives first
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               par_d   = dat_s;
               state_d = S_STOP;
            end
            S_STOP: begin
               state_d = S_IDLE;
               // Odd parity over data plus parity bit, and stop bit high.
               if (dat_s && (^{shift_q, par_q})) accept = 1'b1;
               else                               err    = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end else if (state_q != S_IDLE) begin
         if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d  = S_IDLE;
            to_cnt_d = '0;
            shift_d  = '0;
            err      = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end

      if (accept) begin
         scancode_d = shift_q;
         if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
         end else begin
            // A make code writes 0 (pressed), a break code writes 1.
            case ({ext_q, shift_q})
               9'h01D:  keys_left_d[1]  = brk_q;
               9'h01B:  keys_left_d[0]  = brk_q;
               9'h175:  keys_right_d[1] = brk_q;
               9'h172:  keys_right_d[0] = brk_q;
               default: ;
            endcase
            brk_d = 1'b0;
            ext_d = 1'b0;
         end
      end

`ifdef PS2_ERR_RELEASE_EN
      if (err) begin
         keys_left_d  = 2'b11;
         keys_right_d = 2'b11;
         brk_d        = 1'b0;
         ext_d        = 1'b0;
      end
`endif

      code_valid_d = accept;
      frame_err_d  = err;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         to_cnt_q     <= '0;
         scancode_q   <= 8'h00;
         keys_left_q  <= 2'b11;
         keys_right_q <= 2'b11;
         brk_q        <= 1'b0;
         ext_q        <= 1'b0;
         code_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         to_cnt_q     <= to_cnt_d;
         scancode_q   <= scancode_d;
         keys_left_q  <= keys_left_d;
         keys_right_q <= keys_right_d;
         brk_q        <= brk_d;
         ext_q        <= ext_d;
         code_valid_q <= code_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign keys_left  = keys_left_q;
   assign keys_right = keys_right_q;
   assign scancode   = scancode_q;
   assign code_valid = code_valid_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed testbench for ps2_key_decoder. Uses a short timeout and a short
// PS/2 bit period so the whole run stays small.
module tb_ps2_key_decoder;

   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 1000;
   localparam int HALF       = 24;   // clk cycles per PS/2 half bit

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic [1:0] keys_left;
   logic [1:0] keys_right;
   logic [7:0] scancode;
   logic       code_valid;
   logic       frame_err;

   ps2_key_decoder #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_dat   (ps2_dat),
      .keys_left (keys_left),
      .keys_right(keys_right),
      .scancode  (scancode),
      .code_valid(code_valid),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Pulse monitor
   int cv_cnt = 0;
   int fe_cnt = 0;
   int both_cnt = 0;
   logic [1:0] fe_keys_left = 2'b00;

   always @(negedge clk) begin
      if (code_valid) cv_cnt++;
      if (frame_err) begin
         fe_cnt++;
         fe_keys_left = keys_left;
      end
      if (code_valid && frame_err) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
      return {1'b1, (~^b) ^ bad_par, b, 1'b0};
   endfunction

   // Clock out the first nbits of a frame, LSB (start bit) first.
   task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = bits[i];
         if (glitch && (i == 3 || i == 6)) begin
            wait_cyc(4);
            ps2_clk = 1'b0;
            wait_cyc((i == 3) ? 3 : 7);
            ps2_clk = 1'b1;
         end
         wait_cyc(HALF);
         ps2_clk = 1'b0;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
      wait_cyc(2 * HALF);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(mk_frame(b, 1'b0), 11, 1'b0);
   endtask

   int cv0, fe0;

   initial begin
      wait_cyc(5);
      rst = 1'b0;
      wait_cyc(1);
      chk("rst_keys_left",  keys_left,  2'b11);
      chk("rst_keys_right", keys_right, 2'b11);
      chk("rst_scancode",   scancode,   8'h00);
      chk("rst_code_valid", code_valid, 1'b0);
      chk("rst_frame_err",  frame_err,  1'b0);

      // W make
      cv0 = cv_cnt;
      send_byte(8'h1D);
      $display("tx 1D: scancode=%h keys_left=%b keys_right=%b", scancode, keys_left, keys_right);
      chk("w_make_cv",    cv_cnt - cv0, 1);
      chk("w_make_code",  scancode,     8'h1D);
      chk("w_make_left",  keys_left,    2'b01);
      chk("w_make_right", keys_right,   2'b11);

      // W break: only takes effect after the 1D byte
      cv0 = cv_cnt;
      send_byte(8'hF0);
      $display("tx F0: keys_left=%b", keys_left);
      chk("f0_cv",   cv_cnt - cv0, 1);
      chk("f0_left", keys_left,    2'b01);
      send_byte(8'h1D);
      $display("tx 1D: keys_left=%b", keys_left);
      chk("w_brk_cv",   cv_cnt - cv0, 2);
      chk("w_brk_left", keys_left,    2'b11);

      // Down arrow make, then non-extended 72 (keypad 2) ignored
      send_byte(8'hE0);
      send_byte(8'h72);
      $display("tx E0 72: keys_right=%b", keys_right);
      chk("down_make_right", keys_right, 2'b10);
      send_byte(8'h72);
      $display("tx 72: keys_right=%b scancode=%h", keys_right, scancode);
      chk("kp2_right", keys_right, 2'b10);
      chk("kp2_code",  scancode,   8'h72);

      // Down arrow break (E0 F0 72)
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h72);
      $display("tx E0 F0 72: keys_right=%b", keys_right);
      chk("down_brk_right", keys_right, 2'b11);

      // Bad parity frame
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_bits(mk_frame(8'h1B, 1'b1), 11, 1'b0);
      $display("tx 1B bad parity: fe=%0d cv=%0d keys_left=%b", fe_cnt - fe0, cv_cnt - cv0, keys_left);
      chk("badpar_fe",   fe_cnt - fe0, 1);
      chk("badpar_cv",   cv_cnt - cv0, 0);
      chk("badpar_left", keys_left,    2'b11);
      chk("badpar_code", scancode,     8'h72);

      // Held W across a bad frame
      send_byte(8'h1D);
      chk("prew_left", keys_left, 2'b01);
      fe0 = fe_cnt;
      send_bits(mk_frame(8'h1B, 1'b1), 11, 1'b0);
      $display("tx 1B bad parity with W held: keys_left at err=%b", fe_keys_left);
      chk("held_fe", fe_cnt - fe0, 1);
`ifdef PS2_ERR_RELEASE_EN
      chk("held_fe_left", fe_keys_left, 2'b11);
`else
      chk("held_fe_left", fe_keys_left, 2'b01);
`endif
      send_byte(8'hF0);
      send_byte(8'h1D);
      chk("w_release_left", keys_left, 2'b11);

      // Timeout: start bit plus 4 data bits, then idle
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_bits(mk_frame(8'h5A, 1'b0), 5, 1'b0);
      chk("partial_no_err", fe_cnt - fe0, 0);
      wait_cyc(TIMEOUT + 100);
      $display("tx partial frame: fe=%0d cv=%0d", fe_cnt - fe0, cv_cnt - cv0);
      chk("timeout_fe",   fe_cnt - fe0, 1);
      chk("timeout_cv",   cv_cnt - cv0, 0);
      chk("timeout_code", scancode,     8'h1D);
      send_byte(8'hE0);
      send_byte(8'h75);
      $display("tx E0 75: keys_right=%b", keys_right);
      chk("up_make_right", keys_right, 2'b01);
      chk("up_make_code",  scancode,   8'h75);

      // Clock glitches of 3 and 7 cycles inside the S make frame
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_bits(mk_frame(8'h1B, 1'b0), 11, 1'b1);
      $display("tx 1B glitched: scancode=%h keys_left=%b", scancode, keys_left);
      chk("glitch_cv",   cv_cnt - cv0, 1);
      chk("glitch_fe",   fe_cnt - fe0, 0);
      chk("glitch_code", scancode,     8'h1B);
      chk("glitch_left", keys_left,    2'b10);

      // Reset mid-frame after an E0 prefix
      send_byte(8'hE0);
      send_bits(mk_frame(8'h75, 1'b0), 4, 1'b0);
      rst = 1'b1;
      wait_cyc(1);
      $display("reset mid-frame: keys_left=%b keys_right=%b scancode=%h", keys_left, keys_right, scancode);
      chk("mrst_left",  keys_left,  2'b11);
      chk("mrst_right", keys_right, 2'b11);
      chk("mrst_code",  scancode,   8'h00);
      chk("mrst_cv",    code_valid, 1'b0);
      chk("mrst_fe",    frame_err,  1'b0);
      rst = 1'b0;
      wait_cyc(2 * HALF);
      fe0 = fe_cnt;
      send_byte(8'h75);
      $display("tx 75 after reset: keys_right=%b scancode=%h", keys_right, scancode);
      chk("post_rst_right", keys_right,   2'b11);
      chk("post_rst_code",  scancode,     8'h75);
      send_byte(8'h1D);
      $display("tx 1D after reset: keys_left=%b", keys_left);
      chk("post_rst_left", keys_left,    2'b01);
      chk("post_rst_fe",   fe_cnt - fe0, 0);

      chk("cv_fe_overlap", both_cnt, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
